// File: rtl/lane_stripe_demux_if.sv
// Symbol-in / striped-word-out bundle for lane_stripe_demux.
// master drives symbols and observes words; slave is the demux itself.
interface lane_stripe_demux_if #(
  parameter int unsigned LANES = 4
) ();
  logic                 valid_in;
  logic [7:0]           data_in;
  logic                 k_in;
  logic                 valid_out;
  logic [8*LANES-1:0]   data_out;
  logic [LANES-1:0]     k_out;
  logic                 sop_out;
  logic                 eop_out;
  logic                 err_out;
  logic                 in_pkt;
  logic [15:0]          skp_cnt;

  modport master (
    output valid_in, data_in, k_in,
    input  valid_out, data_out, k_out, sop_out, eop_out, err_out, in_pkt, skp_cnt
  );

  modport slave (
    input  valid_in, data_in, k_in,
    output valid_out, data_out, k_out, sop_out, eop_out, err_out, in_pkt, skp_cnt
  );
endinterface

// File: rtl/lane_stripe_demux.sv
// Stripes a K/data symbol stream across LANES lanes, keeping STP/SDP..END/EDB
// packets lane-aligned, padding partial words with IDL and optionally dropping SKP.
module lane_stripe_demux #(
  parameter int unsigned LANES    = 4,
  parameter bit          DROP_SKP = 1'b1
) (
  input logic              clk,
  input logic              reset_L,
  lane_stripe_demux_if.slave bus
);
  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_COM = 8'hBC;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [8*LANES-1:0] wbuf_d;
  logic [LANES-1:0]   wbuf_k;
  logic               acc_sop;
  logic               acc_err;

  logic               is_skp, is_start, is_end, is_known, sym_err, in_pk, last_lane;
  logic [8*LANES-1:0] fill_d, close_d;
  logic [LANES-1:0]   fill_k, close_k;

  always_comb begin
    is_skp    = bus.k_in && (bus.data_in == K_SKP);
    is_start  = bus.k_in && (bus.data_in == K_STP || bus.data_in == K_SDP);
    is_end    = bus.k_in && (bus.data_in == K_END || bus.data_in == K_EDB);
    is_known  = is_start || is_end || is_skp ||
                (bus.k_in && (bus.data_in == K_IDL || bus.data_in == K_FTS ||
                              bus.data_in == K_COM));
    in_pk     = (state == S_PKT);
    last_lane = (idx == IW'(LANES - 1));
    sym_err   = (!bus.k_in && !in_pk) || (bus.k_in && !is_known) || (is_end && !in_pk);

    // fill_* = buffer with this symbol placed at idx; close_* = buffer padded from idx
    fill_d  = '0;
    fill_k  = '0;
    close_d = '0;
    close_k = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(idx)) begin
        fill_d[8*i +: 8]  = wbuf_d[8*i +: 8];
        fill_k[i]         = wbuf_k[i];
        close_d[8*i +: 8] = wbuf_d[8*i +: 8];
        close_k[i]        = wbuf_k[i];
      end else if (i == 32'(idx)) begin
        fill_d[8*i +: 8]  = bus.data_in;
        fill_k[i]         = bus.k_in;
        close_d[8*i +: 8] = K_IDL;
        close_k[i]        = 1'b1;
      end else begin
        fill_d[8*i +: 8]  = K_IDL;
        fill_k[i]         = 1'b1;
        close_d[8*i +: 8] = K_IDL;
        close_k[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state         <= S_IDLE;
      idx           <= '0;
      wbuf_d        <= '0;
      wbuf_k        <= '0;
      acc_sop       <= 1'b0;
      acc_err       <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.k_out     <= '0;
      bus.sop_out   <= 1'b0;
      bus.eop_out   <= 1'b0;
      bus.err_out   <= 1'b0;
      bus.in_pkt    <= 1'b0;
      bus.skp_cnt   <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      if (bus.valid_in) begin
        if (DROP_SKP && is_skp) begin
          if (bus.skp_cnt != '1) bus.skp_cnt <= bus.skp_cnt + 16'd1;
        end else if (is_start) begin
          if (idx != '0) begin
            bus.valid_out <= 1'b1;
            bus.data_out  <= close_d;
            bus.k_out     <= close_k;
            bus.sop_out   <= acc_sop;
            bus.eop_out   <= in_pk;
            bus.err_out   <= acc_err | in_pk;
          end
          // A restart on a word boundary has no word to close, so the error rides on the new word
          wbuf_d     <= {{(8*(LANES-1)){1'b0}}, bus.data_in};
          wbuf_k     <= {{(LANES-1){1'b0}}, 1'b1};
          idx        <= IW'(1);
          acc_sop    <= 1'b1;
          acc_err    <= in_pk && (idx == '0);
          state      <= S_PKT;
          bus.in_pkt <= 1'b1;
        end else if (last_lane || (is_end && in_pk)) begin
          bus.valid_out <= 1'b1;
          bus.data_out  <= fill_d;
          bus.k_out     <= fill_k;
          bus.sop_out   <= acc_sop;
          bus.eop_out   <= is_end && in_pk;
          bus.err_out   <= acc_err | sym_err | (in_pk && bus.data_in == K_EDB);
          wbuf_d        <= '0;
          wbuf_k        <= '0;
          idx           <= '0;
          acc_sop       <= 1'b0;
          acc_err       <= 1'b0;
          if (is_end && in_pk) begin
            state      <= S_IDLE;
            bus.in_pkt <= 1'b0;
          end
        end else begin
          wbuf_d  <= fill_d;
          wbuf_k  <= fill_k;
          idx     <= idx + IW'(1);
          acc_err <= acc_err | sym_err;
        end
      end
    end
  end
endmodule
